// File: rtl/tx_frontend_ramp.sv
// TX back end between the DUC chain and the DAC interface: IQ balance, DC offset,
// soft on/off gain ramp, rounding with saturation and per-DAC output mux.
module tx_frontend_ramp #(
  parameter int unsigned BASE      = 0,
  parameter int unsigned WIDTH_IN  = 24,
  parameter int unsigned WIDTH_OUT = 16,
  parameter int unsigned CW        = 18,
  parameter int unsigned RAMP_BITS = 10,
  parameter int unsigned IQCOMP_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic [WIDTH_IN-1:0]  tx_i,
  input  logic [WIDTH_IN-1:0]  tx_q,
  input  logic                 run,
  output logic [WIDTH_OUT-1:0] dac_a,
  output logic [WIDTH_OUT-1:0] dac_b,
  output logic                 tx_active,
  output logic                 ramp_busy
);

  localparam int unsigned WI = WIDTH_IN;
  localparam int unsigned WO = WIDTH_OUT;
  localparam int unsigned W1 = WI + 1;
  localparam int unsigned W2 = WI + 2;
  localparam int unsigned PW = WI + CW;
  localparam int unsigned GW = RAMP_BITS + 1;
  localparam int unsigned WX = WI + GW + 1;
  localparam int unsigned SH = WI - WO;

  localparam logic [GW-1:0]        FULL    = {1'b1, {RAMP_BITS{1'b0}}};
  localparam logic signed [W2-1:0] IN_MAX  = {3'b000, {(WI-1){1'b1}}};
  localparam logic signed [W2-1:0] IN_MIN  = {3'b111, {(WI-1){1'b0}}};
  localparam logic signed [W1-1:0] OUT_MAX = {{(W1-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [W1-1:0] OUT_MIN = {{(W1-WO+1){1'b1}}, {(WO-1){1'b0}}};
  localparam logic signed [W1-1:0] RND     = {{(W1-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [WO-1:0] DAC_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic signed [WO-1:0] DAC_MIN = {1'b1, {(WO-1){1'b0}}};

  localparam logic [7:0] A_IDCO  = 8'(BASE);
  localparam logic [7:0] A_QDCO  = 8'(BASE + 1);
  localparam logic [7:0] A_MAG   = 8'(BASE + 2);
  localparam logic [7:0] A_PHASE = 8'(BASE + 3);
  localparam logic [7:0] A_MUX   = 8'(BASE + 4);
  localparam logic [7:0] A_STEP  = 8'(BASE + 5);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_ON, S_DOWN} state_e;

  logic signed [WI-1:0] i_dco_q, q_dco_q;
  logic signed [CW-1:0] mag_q, phase_q;
  logic [7:0]           mux_q;
  logic [RAMP_BITS-1:0] step_q;

  logic signed [WI-1:0] s1_i_q, s1_q_q, s2_i_q, s2_q_q, s3_i_q, s3_q_q, s4_i_q, s4_q_q;
  logic signed [W1-1:0] s1_ci_q, s1_cq_q;
  logic signed [WO-1:0] s5_i_q, s5_q_q;
  logic [WO-1:0]        dac_a_q, dac_b_q;

  logic signed [WI-1:0] s2_i_d, s2_q_d, s3_i_d, s3_q_d, s4_i_d, s4_q_d;
  logic signed [WO-1:0] s5_i_d, s5_q_d;
  logic [WO-1:0]        dac_a_d, dac_b_d;
  logic signed [W1-1:0] ci_c, cq_c;

  state_e        state_q, state_d;
  logic [GW-1:0] g_q, g_d, step_c, up_val, down_val;
  logic [GW:0]   up_sum;
  logic          tx_active_q, ramp_busy_q;

  logic unused_c;
  assign unused_c = ^{set_data, mux_q[3], mux_q[7], mag_q, phase_q};

  function automatic logic signed [WI-1:0] sat_in(input logic signed [W2-1:0] v);
    logic signed [WI-1:0] r;
    r = WI'(v);
    if (v > IN_MAX) r = WI'(IN_MAX);
    if (v < IN_MIN) r = WI'(IN_MIN);
    return r;
  endfunction

  function automatic logic signed [WO-1:0] sat_out(input logic signed [W1-1:0] v);
    logic signed [WO-1:0] r;
    r = WO'(v);
    if (v > OUT_MAX) r = WO'(OUT_MAX);
    if (v < OUT_MIN) r = WO'(OUT_MIN);
    return r;
  endfunction

  // sel[1:0] picks I / Q / zero, sel[2] negates with the most-negative code clipped
  function automatic logic [WO-1:0] dac_sel(input logic [2:0] sel,
                                            input logic signed [WO-1:0] yi,
                                            input logic signed [WO-1:0] yq);
    logic signed [WO-1:0] v;
    case (sel[1:0])
      2'd0:    v = yi;
      2'd1:    v = yq;
      default: v = '0;
    endcase
    if (sel[2]) v = (v == DAC_MIN) ? DAC_MAX : -v;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_dco_q <= '0;
      q_dco_q <= '0;
      mag_q   <= '0;
      phase_q <= '0;
      mux_q   <= 8'h10;
      step_q  <= '0;
    end else if (set_stb) begin
      if (set_addr == A_IDCO)  i_dco_q <= set_data[WI-1:0];
      if (set_addr == A_QDCO)  q_dco_q <= set_data[WI-1:0];
      if (set_addr == A_MAG)   mag_q   <= set_data[CW-1:0];
      if (set_addr == A_PHASE) phase_q <= set_data[CW-1:0];
      if (set_addr == A_MUX)   mux_q   <= set_data[7:0];
      if (set_addr == A_STEP)  step_q  <= set_data[RAMP_BITS-1:0];
    end
  end

  // Balance correction terms; without IQ compensation the stage is a plain delay
  if (IQCOMP_EN != 0) begin : g_iq
    logic signed [PW-1:0] prod_i_c, prod_q_c;
    assign prod_i_c = PW'($signed(tx_i)) * PW'(mag_q);
    assign prod_q_c = PW'($signed(tx_i)) * PW'(phase_q);
    assign ci_c     = W1'(prod_i_c >>> (CW - 1));
    assign cq_c     = W1'(prod_q_c >>> (CW - 1));
  end else begin : g_no_iq
    assign ci_c = '0;
    assign cq_c = '0;
  end

  always_comb begin
    logic signed [WX-1:0] pg_i, pg_q;
    s2_i_d  = sat_in(W2'(s1_i_q) + W2'(s1_ci_q));
    s2_q_d  = sat_in(W2'(s1_q_q) + W2'(s1_cq_q));
    s3_i_d  = sat_in(W2'(s2_i_q) + W2'(i_dco_q));
    s3_q_d  = sat_in(W2'(s2_q_q) + W2'(q_dco_q));
    pg_i    = WX'(s3_i_q) * WX'($signed({1'b0, g_q}));
    pg_q    = WX'(s3_q_q) * WX'($signed({1'b0, g_q}));
    s4_i_d  = WI'(pg_i >>> RAMP_BITS);
    s4_q_d  = WI'(pg_q >>> RAMP_BITS);
    s5_i_d  = sat_out((W1'(s4_i_q) + RND) >>> SH);
    s5_q_d  = sat_out((W1'(s4_q_q) + RND) >>> SH);
    dac_a_d = dac_sel(mux_q[2:0], s5_i_q, s5_q_q);
    dac_b_d = dac_sel(mux_q[6:4], s5_i_q, s5_q_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_i_q  <= '0; s1_q_q  <= '0; s1_ci_q <= '0; s1_cq_q <= '0;
      s2_i_q  <= '0; s2_q_q  <= '0; s3_i_q  <= '0; s3_q_q  <= '0;
      s4_i_q  <= '0; s4_q_q  <= '0; s5_i_q  <= '0; s5_q_q  <= '0;
      dac_a_q <= '0; dac_b_q <= '0;
    end else begin
      s1_i_q  <= tx_i;   s1_q_q  <= tx_q;
      s1_ci_q <= ci_c;   s1_cq_q <= cq_c;
      s2_i_q  <= s2_i_d; s2_q_q  <= s2_q_d;
      s3_i_q  <= s3_i_d; s3_q_q  <= s3_q_d;
      s4_i_q  <= s4_i_d; s4_q_q  <= s4_q_d;
      s5_i_q  <= s5_i_d; s5_q_q  <= s5_q_d;
      dac_a_q <= dac_a_d;
      dac_b_q <= dac_b_d;
    end
  end

  // A zero step means the full swing in a single cycle
  assign step_c   = (step_q == '0) ? FULL : {1'b0, step_q};
  assign up_sum   = {1'b0, g_q} + {1'b0, step_c};
  assign up_val   = (up_sum >= {1'b0, FULL}) ? FULL : up_sum[GW-1:0];
  assign down_val = (g_q > step_c) ? (g_q - step_c) : '0;

  // Reversing run mid-ramp holds g for one cycle before heading the other way
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    case (state_q)
      S_IDLE: begin
        g_d = '0;
        if (run) begin
          g_d     = up_val;
          state_d = (up_val == FULL) ? S_ON : S_UP;
        end
      end
      S_UP: begin
        if (!run) begin
          state_d = S_DOWN;
        end else begin
          g_d = up_val;
          if (up_val == FULL) state_d = S_ON;
        end
      end
      S_ON: begin
        g_d = FULL;
        if (!run) begin
          g_d     = down_val;
          state_d = (down_val == '0) ? S_IDLE : S_DOWN;
        end
      end
      S_DOWN: begin
        if (run) begin
          state_d = S_UP;
        end else begin
          g_d = down_val;
          if (down_val == '0) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        g_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      tx_active_q <= 1'b0;
      ramp_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      tx_active_q <= (g_d != '0);
      ramp_busy_q <= (state_d == S_UP) || (state_d == S_DOWN);
    end
  end

  assign dac_a     = dac_a_q;
  assign dac_b     = dac_b_q;
  assign tx_active = tx_active_q;
  assign ramp_busy = ramp_busy_q;

endmodule

// File: doc/tx_frontend_ramp.md
Name: tx_frontend_ramp

Overview:
Parametrised next-generation TX DSP back end. Per-sample chain: IQ balance, DC offset, programmable soft on/off gain ramp, rounding with saturation, per-DAC output mux with optional inversion. Sits between the TX DSP core (duc chain) and the DAC interface. The ramp removes the spectral splatter a hard `run` edge causes. Everything runs in one clock domain; settings bus and datapath share that clock.

Parameters:
BASE, 0, settings-bus base address; registers at BASE+0..BASE+5.
WIDTH_IN, 24, tx_i/tx_q and internal datapath width, signed.
WIDTH_OUT, 16, dac_a/dac_b width, signed; WIDTH_OUT < WIDTH_IN.
CW, 18, IQ-correction coefficient width, signed Q1.(CW-1).
RAMP_BITS, 10, ramp gain resolution; unity gain FULL = 2^RAMP_BITS.
IQCOMP_EN, 1, 0 = balance multipliers removed, balance stage is a plain register, latency unchanged.

Ports:
clk  in  1  sole clock.
rst  in  1  asynchronous, active-low reset.
set_stb  in  1  settings write strobe.
set_addr  in  8  settings address.
set_data  in  32  settings data.
tx_i  in  WIDTH_IN  I sample, valid every cycle.
tx_q  in  WIDTH_IN  Q sample, valid every cycle.
run  in  1  transmit enable; edges start ramps.
dac_a  out  WIDTH_OUT  DAC A sample.
dac_b  out  WIDTH_OUT  DAC B sample.
tx_active  out  1  high when gain g != 0.
ramp_busy  out  1  high in UP or DOWN.

Behaviour:
- rst low clears, at once: all settings to defaults, pipeline registers 0, dac_a/dac_b 0, g 0, state IDLE, tx_active 0, ramp_busy 0.
- Settings (write when set_stb and set_addr match):
  - +0 i_dco[WIDTH_IN-1:0], default 0
  - +1 q_dco, default 0
  - +2 mag_corr[CW-1:0], default 0
  - +3 phase_corr, default 0
  - +4 mux_ctrl[7:0], default 0x10
  - +5 ramp_step[RAMP_BITS-1:0], default 0
- Pipeline, one register per stage; fixed latency 6 from tx_i/tx_q to dac_a/dac_b:
  - S1: ci = (tx_i*mag_corr)>>>(CW-1); cq = (tx_i*phase_corr)>>>(CW-1). Arithmetic shift (floor). Inputs are delayed to stay aligned.
  - S2: ib = sat(i+ci); qb = sat(q+cq), at WIDTH_IN. With IQCOMP_EN=0, ci=cq=0.
  - S3: io = sat(ib+i_dco); qo = sat(qb+q_dco).
  - S4: x = (o*g)>>>RAMP_BITS, g unsigned 0..FULL. g=FULL is exact passthrough.
  - S5: y = sat((x + 2^(WIDTH_IN-WIDTH_OUT-1))>>>(WIDTH_IN-WIDTH_OUT)) to WIDTH_OUT (round half up).
  - S6: output mux per DAC, nibble [3:0] = A, [7:4] = B.
    - bits[1:0]: 0 = I, 1 = Q, 2/3 = zero.
    - bit2 = invert; -(-2^(WIDTH_OUT-1)) saturates to 2^(WIDTH_OUT-1)-1.
- sat() clips to [-2^(W-1), 2^(W-1)-1].
- Ramp FSM updates g every cycle:
  - IDLE: g=0. run=1 -> UP.
  - UP: g = min(g+ramp_step, FULL); on reaching FULL -> ON. run=0 -> DOWN, g keeps its current value, no step that cycle.
  - ON: g=FULL. run=0 -> DOWN.
  - DOWN: g = max(g-ramp_step, 0); on reaching 0 -> IDLE. run=1 -> UP, no step that cycle.
  - ramp_step=0: instant switching. From IDLE with run=1, g=FULL the next cycle. From ON with run=0, g=0 the next cycle.
  - A ramp_step write mid-ramp takes effect on the next cycle.
- g is registered; its effect on the output appears 3 cycles after g changes (S4..S6).
- tx_active = (g!=0); ramp_busy = state in {UP, DOWN}. Both registered from FSM state.

Test Plan:
1. Stream data, pulse rst low mid-stream -> dac_a=dac_b=0 and flags 0 immediately; after release, defaults hold (A=I, B=Q).
2. ramp_step=0, run=1, tx_i=0x012380, tx_q=0xFFFF00 -> dac_a=0x0124, dac_b=0xFFFF, starting 6 cycles after the first sample with g=FULL.
3. RAMP_BITS=8, ramp_step=64, tx_i=0x100000, run rises -> g 64,128,192,256; dac_a 0x0400,0x0800,0x0C00,0x1000. Drop run in ON -> 0x0C00,0x0800,0x0400,0x0000, then IDLE, tx_active=0.
4. Same setup, drop run when g=128 -> g 128 (hold),64,0; raise run at g=64 -> g 64 (hold),128,... no glitch.
5. i_dco=0x7FFFFF, tx_i=0x400000 -> dac_a=0x7FFF; with invert -> 0x8001. i_dco=0xFFFFFF, tx_i=0x800000 -> 0x8000; with invert -> 0x7FFF.
6. mag_corr=phase_corr=0x10000 (0.5), tx_i=0x200000, tx_q=0 -> dac_a=0x3000, dac_b=0x1000. IQCOMP_EN=0 build -> 0x2000, 0x0000, same latency.
